pipe_ksa_adder: RTL

PIPE_KSA_ADDER -- requirements
Module: pipe_ksa_adder

---
 rtl/pipe_ksa_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_ksa_adder.sv
// pipe_ksa_adder
//   Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake.
//   Stage 0 registers the generate/propagate vectors (carry-in folded into
//   bit 0). Each following stage applies LPS prefix levels. The last stage
//   forms the sum, carry-out and signed overflow into the output registers.
//   Latency is ceil(log2(WIDTH)/LPS) + 1 cycles. A stalled output freezes
//   the whole pipe.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   operand set present on X, Y, CIN, SUB
//   IN_READY   operands accepted this cycle (equals the advance enable)
//   X, Y       operands, WIDTH bits
//   CIN        carry-in, used for addition only
//   SUB        0: X+Y+CIN   1: X-Y
//   OUT_VALID  S/COUT/OVF hold a result
//   OUT_READY  consumer takes the result this cycle
//   S          sum/difference modulo 2^WIDTH
//   COUT       carry out of the MSB (for subtraction, 1 = no borrow)
//   OVF        two's-complement overflow
module pipe_ksa_adder #(
    parameter int WIDTH = 12,
    parameter int LPS   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int L   = $clog2(WIDTH);
    localparam int NST = (L + LPS - 1) / LPS;

    // Apply Kogge-Stone levels lo..hi (level k spans 2^(k-1)).
    // Returns the group-generate vector if sel_g is set, else group-propagate.
    // Bits below the span already hold a complete group from bit 0 and pass through.
    function automatic logic [WIDTH-1:0] ks_levels(input logic [WIDTH-1:0] g_in,
                                                   input logic [WIDTH-1:0] p_in,
                                                   input int lo,
                                                   input int hi,
                                                   input logic sel_g);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] low;
        int span;
        g = g_in;
        p = p_in;
        for (int k = 1; k <= L; k++) begin
            if (k >= lo && k <= hi) begin
                span = 1 << (k - 1);
                low  = ~({WIDTH{1'b1}} << span);
                g    = g | ((g << span) & p);
                p    = p & ((p << span) | low);
            end
        end
        return sel_g ? g : p;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic             cin_in;

    logic [WIDTH-1:0] g_pn  [NST];
    logic [WIDTH-1:0] p_pn  [NST];
    logic [WIDTH-1:0] p0_pn [NST];
    logic [NST-1:0]   cin_pn;
    logic [NST-1:0]   vld_pn;

    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] c_fin;
    logic [WIDTH-1:0] s_fin;

    assign en       = OUT_READY | ~OUT_VALID;
    assign IN_READY = en;

    always_comb begin
        b_in    = SUB ? ~Y : Y;
        cin_in  = SUB | CIN;
        p_in    = X ^ b_in;
        g_in    = X & b_in;
        g_in[0] = g_in[0] | (p_in[0] & cin_in);
    end

    // Final stage: remaining prefix levels, then carries into each bit.
    always_comb begin
        g_fin = ks_levels(g_pn[NST-1], p_pn[NST-1], (NST - 1) * LPS + 1, L, 1'b1);
        c_fin = {g_fin[WIDTH-2:0], cin_pn[NST-1]};
        s_fin = p0_pn[NST-1] ^ c_fin;
    end

    // Control: valid bits and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_pn    <= '0;
            OUT_VALID <= 1'b0;
            S         <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else if (en) begin
            vld_pn[0] <= IN_VALID;
            for (int j = 1; j < NST; j++) begin
                vld_pn[j] <= vld_pn[j-1];
            end
            OUT_VALID <= vld_pn[NST-1];
            S         <= s_fin;
            COUT      <= g_fin[WIDTH-1];
            OVF       <= c_fin[WIDTH-1] ^ g_fin[WIDTH-1];
        end
    end

    // Datapath stages; contents are don't-care while the matching valid is 0.
    always_ff @(posedge CLK) begin
        if (en) begin
            // stage 0: GP generation
            g_pn[0]   <= g_in;
            p_pn[0]   <= p_in;
            p0_pn[0]  <= p_in;
            cin_pn[0] <= cin_in;
            // stages 1..NST-1: LPS prefix levels each
            for (int j = 1; j < NST; j++) begin
                g_pn[j]   <= ks_levels(g_pn[j-1], p_pn[j-1], (j - 1) * LPS + 1, j * LPS, 1'b1);
                p_pn[j]   <= ks_levels(g_pn[j-1], p_pn[j-1], (j - 1) * LPS + 1, j * LPS, 1'b0);
                p0_pn[j]  <= p0_pn[j-1];
                cin_pn[j] <= cin_pn[j-1];
            end
        end
    end

endmodule
